wb_uart: RTL and testbench

WB_UART -- requirements
Module: wb_uart

---
 rtl/wb_uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/wb_uart.sv | 253 +++++++++++++++++++++++++
 tb/tb_wb_uart.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_pkg.sv
// Shared register map, STATUS bit positions and FSM encodings for the Wishbone UART.
package wb_uart_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_DIVISOR = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_TX_BUSY    = 2;
  localparam int ST_RX_VALID   = 3;
  localparam int ST_RX_OVERRUN = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so clearing the array would only add logic.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wb_uart.sv
// Wishbone-attached 8N1 UART: TX FIFO feeding a serialiser, single-byte RX
// holding register with valid/overrun flags and a level interrupt.
module wb_uart
  import wb_uart_pkg::*;
#(
  parameter int          WB_DATA_WIDTH   = 32,
  parameter int          WB_ADDR_WIDTH   = 32,
  parameter int          WB_SEL_WIDTH    = 4,
  parameter int          TX_FIFO_DEPTH   = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic                     uart_tx_o,
  input  logic                     uart_rx_i,
  output logic                     irq_o
);

  localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

  logic            ack_q, ack_d;
  logic [15:0]     divisor_q, divisor_d;
  logic [1:0]      reg_sel;
  logic            wr_en, rd_en, data_rd, div_wr;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_count;

  tx_state_e       tx_state_q, tx_state_d;
  logic [15:0]     tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [15:0]     rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic            rx_done;

  logic            unused_bits;
  assign unused_bits = ^{wb_addr_i, wb_data_i, wb_sel_i, fifo_count};

  // Bus side effects happen only in the ack cycle, using the held request.
  assign reg_sel   = wb_addr_i[3:2];
  assign ack_d     = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr_en     = ack_q & wb_we_i;
  assign rd_en     = ack_q & ~wb_we_i;
  assign fifo_push = wr_en & (reg_sel == ADDR_DATA) & wb_sel_i[0];
  assign data_rd   = rd_en & (reg_sel == ADDR_DATA);
  assign div_wr    = wr_en & (reg_sel == ADDR_DIVISOR) & (wb_sel_i[1:0] == 2'b11);
  assign divisor_d = div_wr ? wb_data_i[15:0] : divisor_q;

  assign wb_ack_o  = ack_q;
  assign irq_o     = rx_valid_q;

  always_comb begin
    wb_data_o = '0;
    if (rd_en) begin
      case (reg_sel)
        ADDR_DATA:    wb_data_o[7:0] = rx_data_q;
        ADDR_STATUS: begin
          wb_data_o[ST_TX_FULL]    = fifo_full;
          wb_data_o[ST_TX_EMPTY]   = fifo_empty & (tx_state_q == TX_IDLE);
          wb_data_o[ST_TX_BUSY]    = (tx_state_q != TX_IDLE);
          wb_data_o[ST_RX_VALID]   = rx_valid_q;
          wb_data_o[ST_RX_OVERRUN] = rx_overrun_q;
        end
        ADDR_DIVISOR: wb_data_o[15:0] = divisor_q;
        default:      wb_data_o = '0;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (wb_data_i[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_div_d   = divisor_q;
          tx_shift_d = fifo_dout;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d = '0;
        // Chain straight into the next start bit when more data is queued.
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_div_d   = divisor_q;
          tx_shift_d = fifo_dout;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state_q)
      TX_START: uart_tx_o = 1'b0;
      TX_DATA:  uart_tx_o = tx_shift_q[0];
      default:  uart_tx_o = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q && rx_prev_q) begin
          rx_div_d   = divisor_q;
          rx_state_d = RX_START;
        end
      end
      // Detection costs one clock, so div/2 here lands (div+1)/2 into the bit.
      RX_START: if (rx_cnt_q == (rx_div_q >> 1)) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == rx_div_q) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == rx_div_q) begin
        rx_done    = rx_s2_q;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A completing byte overrides a same-cycle DATA read's clear.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    if (data_rd) begin
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end
    if (rx_done) begin
      if (rx_valid_q && !data_rd) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ack_q        <= 1'b0;
      divisor_q    <= DEFAULT_DIVISOR;
      tx_state_q   <= TX_IDLE;
      tx_div_q     <= '0;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_div_q     <= '0;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      ack_q        <= ack_d;
      divisor_q    <= divisor_d;
      tx_state_q   <= tx_state_d;
      tx_div_q     <= tx_div_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      rx_s1_q      <= uart_rx_i;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rx_state_q   <= rx_state_d;
      rx_div_q     <= rx_div_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

endmodule

// File: tb/tb_wb_uart.sv
// Directed bench for wb_uart: register map, TX framing and FIFO, RX flags,
// framing errors, glitch rejection and mid-frame reset. TX timing assumes DIVISOR=3.
module tb_wb_uart;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic [31:0] wb_data_o;
  logic        uart_tx_o;
  logic        uart_rx_i;
  logic        irq_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  logic [7:0] mon_byte_q [$];
  logic       mon_stop_q [$];
  int         mon_start_q [$];
  logic [7:0] mon_b;
  int         mon_st;

  logic [31:0] rd;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_cnt++;

  wb_uart dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wb_addr_i (wb_addr_i),
    .wb_data_i (wb_data_i),
    .wb_we_i   (wb_we_i),
    .wb_sel_i  (wb_sel_i),
    .wb_stb_i  (wb_stb_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_ack_o  (wb_ack_o),
    .wb_data_o (wb_data_o),
    .uart_tx_o (uart_tx_o),
    .uart_rx_i (uart_rx_i),
    .irq_o     (irq_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] off, input logic [31:0] wdata,
                         input logic [3:0] sel, output logic [31:0] rdata);
    wb_addr_i = {28'h0, off};
    wb_we_i   = we;
    wb_data_i = wdata;
    wb_sel_i  = sel;
    wb_stb_i  = 1'b1;
    wb_cyc_i  = 1'b1;
    wait_clks(1);
    check("ack_high", wb_ack_o, 1'b1);
    rdata = wb_data_o;
    wait_clks(1);
    check("ack_one_cycle", wb_ack_o, 1'b0);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] wdata, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_xfer(1'b1, off, wdata, sel, dummy);
  endtask

  task automatic wb_read(input logic [3:0] off, output logic [31:0] rdata);
    wb_xfer(1'b0, off, 32'h0, 4'hF, rdata);
  endtask

  // Serial frame at 4 clocks per bit (DIVISOR=3).
  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      wait_clks(4);
    end
    uart_rx_i = stop;
    wait_clks(4);
    uart_rx_i = 1'b1;
  endtask

  // TX line monitor: decodes frames at bit centres, recording start cycle.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_i === 1'b1 && uart_tx_o === 1'b0) begin
        mon_st = cyc_cnt;
        wait_clks(2);
        for (int i = 0; i < 8; i++) begin
          wait_clks(4);
          mon_b[i] = uart_tx_o;
        end
        wait_clks(4);
        mon_byte_q.push_back(mon_b);
        mon_stop_q.push_back(uart_tx_o);
        mon_start_q.push_back(mon_st);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_i     = 1'b0;
    wb_addr_i = '0;
    wb_data_i = '0;
    wb_we_i   = 1'b0;
    wb_sel_i  = '0;
    wb_stb_i  = 1'b0;
    wb_cyc_i  = 1'b0;
    uart_rx_i = 1'b1;
    wait_clks(3);
    check("rst_ack", wb_ack_o, 1'b0);
    check("rst_data", wb_data_o, 32'h0);
    check("rst_tx", uart_tx_o, 1'b1);
    check("rst_irq", irq_o, 1'b0);
    rst_i = 1'b1;
    wait_clks(1);

    // Register map
    wb_read(4'h8, rd);  check("div_reset", rd, 32'h0000_01B1);
    wb_read(4'h4, rd);  check("status_reset", rd, 32'h0000_0002);
    wb_write(4'h8, 32'hFFFF_0003, 4'hF);
    wb_read(4'h8, rd);  check("div_write", rd, 32'h0000_0003);
    wb_write(4'h8, 32'h0000_0055, 4'h1);
    wb_read(4'h8, rd);  check("div_partial_sel", rd, 32'h0000_0003);
    wb_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    wb_read(4'hC, rd);  check("rsvd_read", rd, 32'h0);
    check("data_idle_zero", wb_data_o, 32'h0);

    // Single TX frame 0x55
    mon_byte_q.delete(); mon_stop_q.delete(); mon_start_q.delete();
    wb_write(4'h0, 32'h0000_0055, 4'h1);
    wb_read(4'h4, rd);  check("status_tx_busy", rd, 32'h0000_0004);
    wait_clks(40);
    wb_read(4'h4, rd);  check("status_tx_done", rd, 32'h0000_0002);
    check("tx55_count", mon_byte_q.size(), 1);
    if (mon_byte_q.size() >= 1) begin
      check("tx55_byte", mon_byte_q[0], 8'h55);
      check("tx55_stop", mon_stop_q[0], 1'b1);
    end

    // FIFO fill: nine writes accepted, tenth dropped while full
    mon_byte_q.delete(); mon_stop_q.delete(); mon_start_q.delete();
    for (int i = 0; i < 9; i++) wb_write(4'h0, 32'hA0 + i, 4'h1);
    wb_read(4'h4, rd);  check("status_full", rd, 32'h0000_0005);
    wb_write(4'h0, 32'h0000_00EE, 4'h1);
    wb_read(4'h4, rd);  check("status_full_after_drop", rd, 32'h0000_0005);
    wait_clks(400);
    check("fifo_frame_count", mon_byte_q.size(), 9);
    for (int i = 0; i < 9 && i < mon_byte_q.size(); i++) begin
      check($sformatf("fifo_byte%0d", i), mon_byte_q[i], 32'hA0 + i);
      check($sformatf("fifo_stop%0d", i), mon_stop_q[i], 1'b1);
      if (i > 0) check($sformatf("fifo_gap%0d", i), mon_start_q[i] - mon_start_q[i-1], 40);
    end
    wb_read(4'h4, rd);  check("status_drained", rd, 32'h0000_0002);

    // RX single byte
    send_rx(8'hA3, 1'b1);
    wait_clks(4);
    check("rx_irq_set", irq_o, 1'b1);
    check("rx_data_out_idle", wb_data_o, 32'h0);
    wb_read(4'h0, rd);  check("rx_data_a3", rd, 32'h0000_00A3);
    check("rx_irq_clear", irq_o, 1'b0);

    // RX overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    wait_clks(4);
    wb_read(4'h4, rd);  check("status_overrun", rd, 32'h0000_001A);
    wb_read(4'h0, rd);  check("rx_keep_first", rd, 32'h0000_0011);
    wb_read(4'h4, rd);  check("status_overrun_clr", rd, 32'h0000_0002);

    // Framing error and glitch
    send_rx(8'h5A, 1'b0);
    wait_clks(4);
    wb_read(4'h4, rd);  check("framing_no_valid", rd, 32'h0000_0002);
    uart_rx_i = 1'b0;
    wait_clks(1);
    uart_rx_i = 1'b1;
    wait_clks(20);
    wb_read(4'h4, rd);  check("glitch_no_valid", rd, 32'h0000_0002);
    send_rx(8'h3C, 1'b1);
    wait_clks(4);
    wb_read(4'h0, rd);  check("rx_recover", rd, 32'h0000_003C);

    // Reset during data bit 3 of a TX frame
    wb_write(4'h0, 32'h0000_0000, 4'h1);
    k = 0;
    while (uart_tx_o !== 1'b0 && k < 20) begin
      wait_clks(1);
      k++;
    end
    check("tx_start_seen", uart_tx_o, 1'b0);
    wait_clks(17);
    check("tx_bit3_low", uart_tx_o, 1'b0);
    rst_i = 1'b0;
    wait_clks(1);
    check("reset_tx_high", uart_tx_o, 1'b1);
    check("reset_irq", irq_o, 1'b0);
    rst_i = 1'b1;
    wait_clks(2);
    wb_read(4'h4, rd);  check("reset_status", rd, 32'h0000_0002);
    wb_read(4'h8, rd);  check("reset_divisor", rd, 32'h0000_01B1);
    check("reset_tx_idle", uart_tx_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
